arb4_rr_ctrl: RTL and testbench
===============================

ARB4_RR_CTRL -- requirements
Module: arb4_rr_ctrl

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive grant cycles per owner while another requester waits; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-004 req  input  4  request lines; req[i] high = requester i wants the shared 4:1 mux path.
REQ-005 gnt  output  4  registered one-hot grant, or all-zero when idle.
REQ-006 sel0  output  1  registered mux select bit 0, equal to bit 0 of owner index.
REQ-007 sel1  output  1  registered mux select bit 1, equal to bit 1 of owner index.
REQ-008 busy  output  1  registered; high exactly when gnt is nonzero.
REQ-009 Select encoding: {sel1,sel0} = 00 routes input 0, 01 input 1, 10 input 2, 11 input 3.

Function
REQ-010 Two states: IDLE (gnt=0) and OWNED (exactly one gnt bit high).
REQ-011 All outputs are registered; a grant decision made from req sampled at edge N appears on gnt/sel/busy after edge N, with no combinational path from req to any output.
REQ-012 Search order: first requesting index from (last+1) mod 4 upward with wrap, where last is the most recently granted index.
REQ-013 IDLE: if any req bit high at the edge, enter OWNED with the owner selected per REQ-012, burst count 0; else remain IDLE.
REQ-014 OWNED, owner k, req[k]=0 at the edge: release; grant next requester per REQ-012 at that same edge, burst count 0, with no idle bubble; if none requesting, enter IDLE.
REQ-015 OWNED, req[k]=1, burst count < MAX_BURST-1: keep owner and increment burst count.
REQ-016 OWNED, req[k]=1, burst count = MAX_BURST-1, another req bit high: switch to next requester per REQ-012, which excludes k, and reset burst count to 0.
REQ-017 OWNED, req[k]=1, burst count = MAX_BURST-1, no other req bit high: keep owner and reset burst count to 0 (no forced release).
REQ-018 MAX_BURST=1: the owner is rotated every cycle whenever another requester waits.
REQ-019 Fairness: with all four requesting continuously, grants cycle 0→1→2→3→0, each for exactly MAX_BURST cycles.
REQ-020 sel0/sel1 update only when a new owner is granted; in IDLE they hold the last owner index.
REQ-021 last updates on every new grant; it is unchanged in IDLE.
REQ-022 Burst counter is 4 bits wide, never exceeds MAX_BURST-1, and never wraps.
REQ-023 A req bit dropping for a non-owner has no effect on the current owner.

Reset
REQ-024 reset high at an edge forces gnt=0000, busy=0, sel0=0, sel1=0, burst count=0, state IDLE, last=3 (so requester 0 has first priority); this overrides all other transitions.
REQ-025 Reset asserted mid-burst drops the grant after that edge; the first grant after reset release follows REQ-013 with last=3.
REQ-026 While reset is held, outputs stay at reset values regardless of req.

Verification
REQ-027 Reset, then req=0100 held: after the first edge, gnt=0100, sel1=1, sel0=0, busy=1; the grant holds indefinitely with no rotation.
REQ-028 MAX_BURST=4, req=1111 held 16 cycles from reset: gnt sequence is 0001×4, 0010×4, 0100×4, 1000×4.
REQ-029 Owner 1 granted, req=0000 next cycle: gnt=0000, busy=0, and {sel1,sel0} stays 01.
REQ-030 Owner 0 mid-burst (count 1), req changes to 1010: the next edge gives gnt=0010 with no idle cycle.
REQ-031 req=1111 with owner 2 at count 2, reset pulsed one cycle: outputs go to zero; after release with req=1111, the first grant is 0001.
REQ-032 MAX_BURST=1, req=1001: gnt alternates 0001, 1000, 0001, … every cycle.

Source files
------------

// File: rtl/arb4_rr_ctrl.sv
// arb4_rr_ctrl: 4-way round-robin arbiter with per-owner burst limit and registered 4:1 mux select.
module arb4_rr_ctrl #(
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic       sel0,
    output logic       sel1,
    output logic       busy
);
    typedef enum logic {IDLE, OWNED} state_t;
    localparam logic [3:0] LIMIT = 4'(MAX_BURST - 1);
    state_t     state;
    logic [1:0] last, sel, nxt;
    logic [3:0] cnt;
    logic       take, drop, at_limit, others;
    assign sel0 = sel[0];
    assign sel1 = sel[1];
    // Scanning downward leaves the nearest index after last as the winner; last itself ranks lowest.
    always_comb begin
        nxt = last;
        for (int i = 4; i >= 1; i--)
            if (req[2'(int'(last) + i)]) nxt = 2'(int'(last) + i);
        at_limit = cnt == LIMIT;
        others   = |(req & ~(4'b0001 << last));
        take     = (state == IDLE || !req[last]) ? |req : at_limit && others;
        drop     = state == OWNED && req == 4'b0000;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            sel   <= 2'd0;
            last  <= 2'd3;
            cnt   <= 4'd0;
        end else if (take) begin
            state <= OWNED;
            gnt   <= 4'b0001 << nxt;
            busy  <= 1'b1;
            sel   <= nxt;
            last  <= nxt;
            cnt   <= 4'd0;
        end else if (drop) begin
            state <= IDLE;
            gnt   <= 4'b0000;
            busy  <= 1'b0;
            cnt   <= 4'd0;
        end else if (state == OWNED) begin
            cnt <= at_limit ? 4'd0 : cnt + 4'd1;
        end
    end
endmodule

// File: tb/tb_arb4_rr_ctrl.sv
// tb_arb4_rr_ctrl: scoreboard bench for the default-burst and single-burst arbiter variants.
module tb_arb4_rr_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req_a = 4'b0000, req_b = 4'b0000;
    logic [3:0] gnt_a, gnt_b;
    logic       sel0_a, sel1_a, busy_a, sel0_b, sel1_b, busy_b;
    logic [5:0] qa[$], qb[$];
    int         checks = 0, failures = 0;

    arb4_rr_ctrl #(.MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset), .req(req_a),
        .gnt(gnt_a), .sel0(sel0_a), .sel1(sel1_a), .busy(busy_a)
    );
    arb4_rr_ctrl #(.MAX_BURST(1)) dut_b (
        .clk(clk), .reset(reset), .req(req_b),
        .gnt(gnt_b), .sel0(sel0_b), .sel1(sel1_b), .busy(busy_b)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, got, exp);
        end
    endtask

    // Expected outputs for the edge following each pushed stimulus.
    initial forever begin
        logic [5:0] e;
        @(posedge clk);
        #1;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            cmp("a_gnt", gnt_a, e[5:2]);
            cmp("a_sel", {2'b00, sel1_a, sel0_a}, {2'b00, e[1:0]});
            cmp("a_busy", {3'b000, busy_a}, {3'b000, e[5:2] != 4'b0000});
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            cmp("b_gnt", gnt_b, e[5:2]);
            cmp("b_sel", {2'b00, sel1_b, sel0_b}, {2'b00, e[1:0]});
            cmp("b_busy", {3'b000, busy_b}, {3'b000, e[5:2] != 4'b0000});
        end
    end

    task automatic sa(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = r;
            req_a = rq;
            qa.push_back({g, s});
        end
    endtask

    task automatic sb(input logic r, input logic [3:0] rq, input logic [3:0] g, input logic [1:0] s, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = r;
            req_b = rq;
            qb.push_back({g, s});
        end
    endtask

    initial begin
        sa(1, 4'b1111, 4'b0000, 2'd0, 2);
        sa(0, 4'b0100, 4'b0100, 2'd2, 6);
        sa(0, 4'b0000, 4'b0000, 2'd2, 2);
        sa(1, 4'b1111, 4'b0000, 2'd0, 1);
        sa(0, 4'b1111, 4'b0001, 2'd0, 4);
        sa(0, 4'b1111, 4'b0010, 2'd1, 4);
        sa(0, 4'b1111, 4'b0100, 2'd2, 4);
        sa(0, 4'b1111, 4'b1000, 2'd3, 4);
        sa(0, 4'b0010, 4'b0010, 2'd1, 1);
        sa(0, 4'b0000, 4'b0000, 2'd1, 2);
        sa(0, 4'b0001, 4'b0001, 2'd0, 2);
        sa(0, 4'b1010, 4'b0010, 2'd1, 4);
        sa(0, 4'b1010, 4'b1000, 2'd3, 1);
        sa(0, 4'b1000, 4'b1000, 2'd3, 5);
        sa(0, 4'b1101, 4'b1000, 2'd3, 1);
        sa(0, 4'b1001, 4'b1000, 2'd3, 1);
        sa(0, 4'b1001, 4'b0001, 2'd0, 1);
        sa(1, 4'b1111, 4'b0000, 2'd0, 1);
        sa(0, 4'b1111, 4'b0001, 2'd0, 4);
        sa(0, 4'b1111, 4'b0010, 2'd1, 4);
        sa(0, 4'b1111, 4'b0100, 2'd2, 3);
        sa(1, 4'b1111, 4'b0000, 2'd0, 1);
        sa(0, 4'b1111, 4'b0001, 2'd0, 2);
        sa(1, 4'b0000, 4'b0000, 2'd0, 1);
        sb(1, 4'b1001, 4'b0000, 2'd0, 1);
        for (int i = 0; i < 4; i++) begin
            sb(0, 4'b1001, 4'b0001, 2'd0, 1);
            sb(0, 4'b1001, 4'b1000, 2'd3, 1);
        end
        sb(0, 4'b1000, 4'b1000, 2'd3, 3);
        sb(0, 4'b0000, 4'b0000, 2'd3, 1);
        repeat (3) @(posedge clk);
        #2;
        cmp("drain", 4'(qa.size() + qb.size()), 4'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
